crt_seq_ctrl: RTL

//  Sequencing controller for CRT RNS-to-binary conversion. Holds moduli/inverse config, precomputes M and Q[i]

---
 rtl/crt_pkg.sv | 32 +++
 rtl/crt_seq_ctrl_if.sv | 37 +++
 rtl/crt_term_unit.sv | 29 ++
 rtl/crt_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
// Shared constants and types for the CRT sequencing controller.
//   MOD_NUM residue channels of MOD_SIZE bits; moduli are MOD_SIZE+1 bits,
//   inverses INV_W bits, and M / Q[i] / accumulator / result are RANGE bits.
package crt_pkg;

  localparam int unsigned MOD_NUM   = 4;
  localparam int unsigned MOD_SIZE  = 5;
  localparam int unsigned INV_W     = 8;
  localparam int unsigned RANGE     = MOD_NUM * MOD_SIZE;
  localparam int unsigned MOD_W     = MOD_SIZE + 1;
  localparam int unsigned IDX_W     = (MOD_NUM > 1) ? $clog2(MOD_NUM) : 1;
  localparam int unsigned RES_BUS_W = MOD_NUM * MOD_SIZE;
  // Full-precision width of Q[i]*m[j] and of one CRT term
  localparam int unsigned TERM_W    = RANGE + MOD_W;
  // Accumulator + term, one bit of headroom so the sum is never truncated
  localparam int unsigned SUM_W     = TERM_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ACC,
    SGN,
    OUT
  } state_e;

  typedef logic [MOD_SIZE-1:0] res_t;
  typedef logic [MOD_W-1:0]    mod_t;
  typedef logic [INV_W-1:0]    inv_t;
  typedef logic [RANGE-1:0]    wide_t;
  typedef logic [IDX_W-1:0]    idx_t;

endpackage

// File: rtl/crt_seq_ctrl_if.sv
// Handshake bundle of the CRT sequencing controller.
//   cfg_*  : config write (cfg_we/idx/mod/inv in, cfg_ready out)
//   in_*   : residue vector in (in_valid/in_res in, in_ready out)
//   out_*  : signed result out (out_valid/out_data/out_err out, out_ready in)
//   busy   : controller not idle
// master drives requests (consumer/producer side), slave is the controller.
interface crt_seq_ctrl_if;
  import crt_pkg::*;

  logic                        cfg_we;
  idx_t                        cfg_idx;
  mod_t                        cfg_mod;
  inv_t                        cfg_inv;
  logic                        cfg_ready;

  logic                        in_valid;
  logic                        in_ready;
  logic [RES_BUS_W-1:0]        in_res;

  logic                        out_valid;
  logic                        out_ready;
  logic signed [RANGE-1:0]     out_data;
  logic                        out_err;

  logic                        busy;

  modport master (
    output cfg_we, cfg_idx, cfg_mod, cfg_inv, in_valid, in_res, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_mod, cfg_inv, in_valid, in_res, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_err, busy
  );

endinterface

// File: rtl/crt_term_unit.sv
// Combinational CRT term: t = ((c * a) mod m) * q.
//   c_i : residue, a_i : modular inverse, m_i : modulus, q_i : M/m
//   t_c : term, full TERM_W precision (always < M for a valid config)
// A zero modulus yields a zero term instead of a divide by zero.
module crt_term_unit
  import crt_pkg::*;
(
  input  res_t              c_i,
  input  inv_t              a_i,
  input  mod_t              m_i,
  input  wide_t             q_i,
  output logic [TERM_W-1:0] t_c
);

  localparam int unsigned CA_W = MOD_SIZE + INV_W;

  logic [CA_W-1:0] ca;
  mod_t            red;

  always_comb begin
    ca  = CA_W'(c_i) * CA_W'(a_i);
    red = '0;
    if (m_i != '0) begin
      red = MOD_W'(ca % CA_W'(m_i));
    end
    t_c = TERM_W'(red) * TERM_W'(q_i);
  end

endmodule

// File: rtl/crt_seq_ctrl.sv
// CRT RNS-to-binary sequencing controller.
//   clk, reset (async, active-low)
//   bus (crt_seq_ctrl_if.slave): config writes, residue input, signed result
// Holds moduli/inverses, recomputes M and Q[i] after any config change,
// then accumulates one CRT term per cycle and maps the result to signed.
// Optional build macro CRT_RESIDUE_CHECK_EN: flag residues C[i] >= m[i]
// through out_err; without it out-of-range residues are reduced silently.
module crt_seq_ctrl
  import crt_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  crt_seq_ctrl_if.slave bus
);

  localparam idx_t LAST_IDX = IDX_W'(MOD_NUM - 1);

  state_e state_q, state_d;
  mod_t   m_q   [MOD_NUM];
  mod_t   m_d   [MOD_NUM];
  inv_t   a_q   [MOD_NUM];
  inv_t   a_d   [MOD_NUM];
  wide_t  q_q   [MOD_NUM];
  wide_t  q_d   [MOD_NUM];
  res_t   res_q [MOD_NUM];
  res_t   res_d [MOD_NUM];
  wide_t  mm_q, mm_d;
  wide_t  acc_q, acc_d;
  idx_t   i_q, i_d;
  idx_t   j_q, j_d;
  logic   dirty_q, dirty_d;
  logic   cfg_bad_q, cfg_bad_d;
  logic   out_valid_q, out_valid_d;
  wide_t  out_data_q, out_data_d;
  logic   out_err_q, out_err_d;
  logic   in_ready_q, in_ready_d;
  logic   busy_q, busy_d;

  logic [TERM_W-1:0] term_c;
  logic [TERM_W-1:0] prep_prod_c;
  logic [TERM_W-1:0] m_prod_c;
  logic [SUM_W-1:0]  sum_c;
  logic              cfg_bad_c;
  logic              res_bad_c;

  // Single shared term unit, muxed by the channel counter
  crt_term_unit u_term (
    .c_i (res_q[i_q]),
    .a_i (a_q[i_q]),
    .m_i (m_q[i_q]),
    .q_i (q_q[i_q]),
    .t_c (term_c)
  );

  // Wide datapath helpers
  always_comb begin
    prep_prod_c = TERM_W'(q_q[i_q]) * TERM_W'(m_q[j_q]);
    m_prod_c    = TERM_W'(q_q[0]) * TERM_W'(m_q[0]);
    sum_c       = SUM_W'(acc_q) + SUM_W'(term_c);
    cfg_bad_c   = 1'b0;
    for (int k = 0; k < MOD_NUM; k++) begin
      if (m_q[k] < mod_t'(2)) cfg_bad_c = 1'b1;
    end
  end

`ifdef CRT_RESIDUE_CHECK_EN
  // Residues and moduli are frozen from accept until the next IDLE
  always_comb begin
    res_bad_c = 1'b0;
    for (int k = 0; k < MOD_NUM; k++) begin
      if (MOD_W'(res_q[k]) >= m_q[k]) res_bad_c = 1'b1;
    end
  end
`else
  assign res_bad_c = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    a_d         = a_q;
    q_d         = q_q;
    res_d       = res_q;
    mm_d        = mm_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    dirty_d     = dirty_q;
    cfg_bad_d   = cfg_bad_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          m_d[bus.cfg_idx] = bus.cfg_mod;
          a_d[bus.cfg_idx] = bus.cfg_inv;
          dirty_d          = 1'b1;
        end
        if (bus.in_valid) begin
          for (int k = 0; k < MOD_NUM; k++) begin
            res_d[k] = bus.in_res[k*MOD_SIZE +: MOD_SIZE];
          end
          i_d   = '0;
          j_d   = '0;
          acc_d = '0;
          // dirty_d so a same-cycle config write is honoured
          if (dirty_d) begin
            for (int k = 0; k < MOD_NUM; k++) q_d[k] = wide_t'(1);
            state_d = PREP;
          end else begin
            state_d = ACC;
          end
        end
      end

      // Q[i] = product of m[j] for j != i, one multiply per cycle
      PREP: begin
        if (i_q != j_q) q_d[i_q] = RANGE'(prep_prod_c);
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            mm_d      = RANGE'(m_prod_c);
            dirty_d   = 1'b0;
            cfg_bad_d = cfg_bad_c;
            i_d       = '0;
            acc_d     = '0;
            state_d   = ACC;
          end else begin
            i_d = i_q + idx_t'(1);
          end
        end else begin
          j_d = j_q + idx_t'(1);
        end
      end

      // Terms are < M, so one conditional subtract keeps acc in [0, M)
      ACC: begin
        if (sum_c >= SUM_W'(mm_q)) acc_d = RANGE'(sum_c - SUM_W'(mm_q));
        else                       acc_d = RANGE'(sum_c);
        if (i_q == LAST_IDX) state_d = SGN;
        else                 i_d     = i_q + idx_t'(1);
      end

      // Upper half of [0, M) maps to negative values
      SGN: begin
        if ({acc_q, 1'b0} >= {1'b0, mm_q}) out_data_d = acc_q - mm_q;
        else                               out_data_d = acc_q;
        out_err_d   = cfg_bad_q | res_bad_c;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      m_q         <= '{default: '0};
      a_q         <= '{default: '0};
      q_q         <= '{default: '0};
      res_q       <= '{default: '0};
      mm_q        <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      dirty_q     <= 1'b1;
      cfg_bad_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      a_q         <= a_d;
      q_q         <= q_d;
      res_q       <= res_d;
      mm_q        <= mm_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      dirty_q     <= dirty_d;
      cfg_bad_q   <= cfg_bad_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_ready = in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = $signed(out_data_q);
  assign bus.out_err   = out_err_q;
  assign bus.busy      = busy_q;

endmodule
